// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared register offsets, FSM encodings and defaults for int_ctrl
package int_ctrl_pkg;

  localparam int NUM_SRC_DEFAULT = 8;
  localparam int ID_W            = 5;

  localparam logic [3:0] INTC_PENDING = 4'h0;
  localparam logic [3:0] INTC_ENABLE  = 4'h4;
  localparam logic [3:0] INTC_CLAIM   = 4'h8;
  localparam logic [3:0] INTC_STATUS  = 4'hC;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_CLAIMED = 2'd2;

  function automatic logic [31:0] status_word(input logic [1:0] state,
                                              input logic [ID_W-1:0] id);
    status_word = {19'd0, id, 6'd0, state};
  endfunction

endpackage

// File: rtl/int_gateway.sv
// rtl/int_gateway.sv - per-source pending/in-service gateway
// INT_CTRL_EDGE_EN selects rising-edge capture; default is level-sensitive.
module int_gateway
  import int_ctrl_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic req,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic set_req;

`ifdef INT_CTRL_EDGE_EN
  logic req_q;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) req_q <= 1'b0;
    else           req_q <= req;
  end

  assign set_req = req & ~req_q;
`else
  assign set_req = req;
`endif

  // Claim beats a same-cycle request; in_service is the registered value,
  // so a request alongside completion re-pends one cycle later.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      if (claim) begin
        pending    <= 1'b0;
        in_service <= 1'b1;
      end else if (set_req && !in_service) begin
        pending <= 1'b1;
      end
      if (complete) in_service <= 1'b0;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - fixed-priority interrupt controller with claim/complete handshake
// Gateway mode selected by INT_CTRL_EDGE_EN (edge) or its absence (level).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               wr_en_i,
  input  logic [31:0]        wr_addr_i,
  input  logic [31:0]        wr_data_i,
  input  logic               rd_en_i,
  input  logic [31:0]        rd_addr_i,
  output logic [31:0]        rd_data_o,
  output logic               int_flag_o
);

  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [1:0]         state;
  logic [ID_W-1:0]    claim_id;
  logic [ID_W-1:0]    best_id;
  logic [3:0]         rd_addr_q;
  logic               claim_rd;
  logic               do_claim;
  logic               do_complete;
  logic               unused_bits;

  assign claim_rd    = rd_en_i && (rd_addr_i[3:0] == INTC_CLAIM);
  assign do_claim    = (state == ST_ASSERT) && claim_rd && (best_id != '0);
  assign do_complete = (state == ST_CLAIMED) && wr_en_i &&
                       (wr_addr_i[3:0] == INTC_CLAIM) &&
                       (wr_data_i[ID_W-1:0] == claim_id);

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    best_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] && enable[i]) best_id = ID_W'(i + 1);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : gen_gw
      int_gateway u_gw (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .req        (irq_src_i[g]),
        .claim      (do_claim && (best_id == ID_W'(g + 1))),
        .complete   (do_complete && (claim_id == ID_W'(g + 1))),
        .pending    (pending[g]),
        .in_service (in_service[g])
      );
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state     <= ST_IDLE;
      claim_id  <= '0;
      enable    <= '0;
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_i[3:0];
      if (wr_en_i && (wr_addr_i[3:0] == INTC_ENABLE)) enable <= wr_data_i[NUM_SRC-1:0];
      case (state)
        ST_IDLE: begin
          if (claim_rd)        claim_id <= '0;
          if (best_id != '0)   state    <= ST_ASSERT;
        end
        ST_ASSERT: begin
          if (do_claim) begin
            claim_id <= best_id;
            state    <= ST_CLAIMED;
          end else if (best_id == '0) begin
            if (claim_rd) claim_id <= '0;
            state <= ST_IDLE;
          end
        end
        ST_CLAIMED: begin
          if (do_complete) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign int_flag_o = (state == ST_ASSERT);

  always_comb begin
    rd_data_o = '0;
    case (rd_addr_q)
      INTC_PENDING: rd_data_o[NUM_SRC-1:0] = pending;
      INTC_ENABLE:  rd_data_o[NUM_SRC-1:0] = enable;
      INTC_CLAIM:   rd_data_o[ID_W-1:0]    = claim_id;
      INTC_STATUS:  rd_data_o = status_word(state, (state == ST_CLAIMED) ? claim_id : '0);
      default:      rd_data_o = '0;
    endcase
  end

  assign unused_bits = ^{wr_addr_i[31:4], rd_addr_i[31:4], wr_data_i, in_service};

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl
module tb_int_ctrl;

  localparam int N = 8;

  logic          sys_clk = 1'b0;
  logic          sys_reset = 1'b1;
  logic [N-1:0]  irq = '0;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          rd_en = 1'b0;
  logic [31:0]   rd_addr = '0;
  logic [31:0]   rd_data;
  logic          int_flag;

  int vec  = 0;
  int miss = 0;

  int_ctrl #(.NUM_SRC(N)) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .irq_src_i  (irq),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .int_flag_o (int_flag)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: 0 = waiting, 1 = requesting CPU, 2 = being serviced.
  bit m_pend[N];
  bit m_ins[N];
  bit m_en[N];
  bit m_prev[N];
  int m_state = 0;
  int m_claim = 0;
  int m_raddr = 0;
  bit m_valid = 1'b0;

  function automatic int m_best();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = '0;
    case (a)
      0:  for (int i = 0; i < N; i++) r[i] = m_pend[i];
      4:  for (int i = 0; i < N; i++) r[i] = m_en[i];
      8:  r = m_claim;
      12: r = m_state + ((m_state == 2) ? (m_claim * 256) : 0);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step();
    int b, ns;
    bit crd, cwr, trig;
    bit np[N];
    bit ni[N];
    if (sys_reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_ins[i] = 0; m_en[i] = 0; m_prev[i] = 0;
      end
      m_state = 0; m_claim = 0; m_raddr = 0; m_valid = 1'b1;
      return;
    end
    b   = m_best();
    crd = rd_en && (rd_addr[3:0] == 4'h8);
    cwr = wr_en && (wr_addr[3:0] == 4'h8);
    np  = m_pend;
    ni  = m_ins;
    ns  = m_state;
    for (int i = 0; i < N; i++) begin
`ifdef INT_CTRL_EDGE_EN
      trig = irq[i] && !m_prev[i];
`else
      trig = irq[i];
`endif
      if (trig && !m_ins[i]) np[i] = 1;
    end
    if (m_state == 0) begin
      if (crd) m_claim = 0;
      if (b != 0) ns = 1;
    end else if (m_state == 1) begin
      if (crd && b != 0) begin
        m_claim = b; np[b-1] = 0; ni[b-1] = 1; ns = 2;
      end else if (b == 0) begin
        if (crd) m_claim = 0;
        ns = 0;
      end
    end else begin
      if (cwr && wr_data[4:0] == m_claim[4:0] && m_claim > 0) begin
        ni[m_claim-1] = 0; ns = 0;
      end
    end
    if (wr_en && wr_addr[3:0] == 4'h4)
      for (int i = 0; i < N; i++) m_en[i] = wr_data[i];
    for (int i = 0; i < N; i++) m_prev[i] = irq[i];
    m_raddr = rd_addr[3:0];
    m_pend  = np;
    m_ins   = ni;
    m_state = ns;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("model_int_flag", {31'd0, int_flag}, (m_state == 1) ? 32'd1 : 32'd0);
      check("model_rd_data", rd_data, m_read(m_raddr));
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    cyc();
    rd_en = 1'b0; rd_addr = '0;
    check(name, rd_data, exp);
  endtask

  task automatic wait_flag(input string name, input int budget);
    int n;
    n = 0;
    while (int_flag !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check(name, {31'd0, int_flag}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_reset = 1'b1;
    repeat (3) cyc();
    sys_reset = 1'b0;
    check("rst_flag", {31'd0, int_flag}, 32'd0);
    rd_chk("rst_pending", 32'h0, 32'h0);
    rd_chk("rst_enable",  32'h4, 32'h0);
    rd_chk("rst_claim",   32'h8, 32'h0);
    rd_chk("rst_status",  32'hC, 32'h0);
    rd_chk("bad_offset",  32'h3, 32'h0);

    wr(32'h4, 32'hFF);
    rd_chk("enable_ff", 32'h4, 32'h000000FF);
    wr(32'h4, 32'hFFFF_FFFF);
    rd_chk("enable_upper_zero", 32'h4, 32'h000000FF);

    // single source, two-cycle latency
    wr(32'h4, 32'h01);
    irq = 8'h01;
    cyc();
    check("lat_cycle1", {31'd0, int_flag}, 32'd0);
    cyc();
    check("lat_cycle2", {31'd0, int_flag}, 32'd1);
    rd_chk("claim_src0", 32'h8, 32'd1);
    check("flag_after_claim", {31'd0, int_flag}, 32'd0);
    rd_chk("status_claimed", 32'hC, 32'h102);
    irq = 8'h00;
    wr(32'h8, 32'd1);
    rd_chk("status_idle", 32'hC, 32'h0);

    // priority plus mismatched completion
    wr(32'h4, 32'h0F);
    irq = 8'h0A;
    wait_flag("flag_pri", 5);
    rd_chk("claim_pri1", 32'h8, 32'd2);
    irq[1] = 1'b0;
    wr(32'h8, 32'd3);
    rd_chk("status_mismatch", 32'hC, 32'h202);
    wr(32'h8, 32'd2);
    check("flag_after_complete", {31'd0, int_flag}, 32'd0);
    wait_flag("flag_pri2", 5);
    rd_chk("claim_pri2", 32'h8, 32'd4);
    irq = 8'h00;
    wr(32'h8, 32'd4);

    // pending but disabled, then enabled
    wr(32'h4, 32'h00);
    irq = 8'h10;
    repeat (3) cyc();
    check("disabled_flag", {31'd0, int_flag}, 32'd0);
    rd_chk("claim_in_idle", 32'h8, 32'd0);
    wr(32'h4, 32'h10);
    check("enable_flag0", {31'd0, int_flag}, 32'd0);
    cyc();
    check("enable_flag1", {31'd0, int_flag}, 32'd1);
    rd_chk("claim_src4", 32'h8, 32'd5);
    irq = 8'h00;
    wr(32'h8, 32'd5);

    // one-cycle pulse on source 2
    wr(32'h4, 32'h04);
    irq[2] = 1'b1;
    cyc();
    irq[2] = 1'b0;
    wait_flag("pulse_flag", 5);
    rd_chk("claim_pulse", 32'h8, 32'd3);
    wr(32'h8, 32'd3);
    cyc(); cyc();
    check("pulse_no_repend", {31'd0, int_flag}, 32'd0);

    // level held through completion
    irq[2] = 1'b1;
    wait_flag("held_flag", 5);
    rd_chk("claim_held", 32'h8, 32'd3);
    wr(32'h8, 32'd3);
`ifdef INT_CTRL_EDGE_EN
    cyc(); cyc(); cyc();
    check("edge_no_repend", {31'd0, int_flag}, 32'd0);
    irq[2] = 1'b0;
`else
    wait_flag("repend_flag", 5);
    rd_chk("claim_repend", 32'h8, 32'd3);
    irq[2] = 1'b0;
    wr(32'h8, 32'd3);
`endif

    // reset while claimed
    wr(32'h4, 32'h01);
    irq = 8'h01;
    wait_flag("flag_pre_rst", 5);
    rd_chk("claim_pre_rst", 32'h8, 32'd1);
    irq = 8'h00;
    sys_reset = 1'b1;
    cyc();
    sys_reset = 1'b0;
    check("rst_mid_flag", {31'd0, int_flag}, 32'd0);
    rd_chk("rst_mid_status", 32'hC, 32'h0);
    rd_chk("rst_mid_enable", 32'h4, 32'h0);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
